frame_update_scheduler: RTL and testbench

//  Sequences once-per-frame game-state updates for the VGA render path.
//  - On each vertical-sync edge: snapshots the frame's collision flags and starts the physics engine.
//  - Waits for the engine's done handshake, then commits the new object coordinates to shadow registers.
//  - render reads only the shadow registers, so coordinates never change mid-frame.

---
 rtl/frame_update_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// Purpose: per-frame scheduler; snapshots collision flags on vsync, runs physics, commits clamped coordinates to shadow registers.
// Latency: vsync fall -> phys_start 3 clk; phys_done sampled at edge N -> coordinates and commit visible after edge N+1.
// Backpressure: none; vsync edges arriving while physics is busy are counted as overruns and dropped.
module frame_update_scheduler #(
    parameter int COORD_W     = 10,
    parameter int FRAME_DIV   = 1,
    parameter int TIMEOUT_CYC = 60000,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int P1_X_INIT   = 64,
    parameter int P2_X_INIT   = 512,
    parameter int PLY_Y_INIT  = 352,
    parameter int BALL_X_INIT = 300,
    parameter int BALL_Y_INIT = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               vga_vs,
    input  logic               player_cover,
    input  logic               COM_cover,
    input  logic               phys_done,
    input  logic [COORD_W-1:0] phys_p1_x,
    input  logic [COORD_W-1:0] phys_p1_y,
    input  logic [COORD_W-1:0] phys_p2_x,
    input  logic [COORD_W-1:0] phys_p2_y,
    input  logic [COORD_W-1:0] phys_ball_x,
    input  logic [COORD_W-1:0] phys_ball_y,
    output logic               phys_start,
    output logic               hit_p1,
    output logic               hit_com,
    output logic [COORD_W-1:0] p1_x,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] p2_x,
    output logic [COORD_W-1:0] p2_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               commit,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         overrun_cnt,
    output logic               timeout
);

    localparam int                 CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]         DIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [COORD_W-1:0] XM       = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM       = COORD_W'(Y_MAX);
    // Coordinate slots: 0 p1_x, 1 p1_y, 2 p2_x, 3 p2_y, 4 ball_x, 5 ball_y (even = x, odd = y).
    localparam logic [COORD_W-1:0] INIT [6] = '{
        COORD_W'(P1_X_INIT), COORD_W'(PLY_Y_INIT),
        COORD_W'(P2_X_INIT), COORD_W'(PLY_Y_INIT),
        COORD_W'(BALL_X_INIT), COORD_W'(BALL_Y_INIT)
    };

    typedef enum logic [1:0] {IDLE, ARM, BUSY, COMMIT} state_t;

    state_t             state_q, state_d;
    logic               vs_s1_q, vs_s2_q, vs_prev_q;
    logic               vs_edge;
    logic [3:0]         div_q, div_d;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic               phys_start_q, phys_start_d;
    logic               hit_p1_q, hit_p1_d, hit_com_q, hit_com_d;
    logic               commit_q, commit_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [7:0]         overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic [COORD_W-1:0] phys_w  [6];
    logic [COORD_W-1:0] cap_q   [6];
    logic [COORD_W-1:0] cap_d   [6];
    logic [COORD_W-1:0] coord_q [6];
    logic [COORD_W-1:0] coord_d [6];

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign phys_w[0] = phys_p1_x;
    assign phys_w[1] = phys_p1_y;
    assign phys_w[2] = phys_p2_x;
    assign phys_w[3] = phys_p2_y;
    assign phys_w[4] = phys_ball_x;
    assign phys_w[5] = phys_ball_y;

    // Falling edge of the synchronized vsync, one cycle after it settles in vs_s2_q.
    assign vs_edge = vs_prev_q & ~vs_s2_q;

    // Two-flop synchronizer for vsync plus the previous-value register for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_s1_q   <= vga_vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    // Next-state logic: frame bookkeeping on every edge, plus the IDLE/ARM/BUSY/COMMIT sequencing.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        busy_cnt_d   = busy_cnt_q;
        phys_start_d = 1'b0;
        commit_d     = 1'b0;
        hit_p1_d     = hit_p1_q;
        hit_com_d    = hit_com_q;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        cap_d        = cap_q;
        coord_d      = coord_q;

        if (vs_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (state_q == BUSY) begin
                // Flags stay frozen while physics consumes them.
                if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
            end else begin
                hit_p1_d  = player_cover;
                hit_com_d = COM_cover;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    if (div_q == DIV_LAST) begin
                        div_d        = 4'd0;
                        phys_start_d = 1'b1;
                        busy_cnt_d   = '0;
                        state_d      = BUSY;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                busy_cnt_d = busy_cnt_q + 1'b1;
                // A done still asserted from a previous transaction must not be taken in the start cycle.
                if (phys_done && !phys_start_q) begin
                    for (int i = 0; i < 6; i++) begin
                        cap_d[i] = clamp(phys_w[i], (i % 2 == 0) ? XM : YM);
                    end
                    state_d = COMMIT;
                end else if (busy_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ARM;
                end
            end
            COMMIT: begin
                coord_d  = cap_q;
                commit_d = 1'b1;
                state_d  = enable ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; coordinates reload their power-on positions.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_q        <= 4'd0;
            busy_cnt_q   <= '0;
            phys_start_q <= 1'b0;
            commit_q     <= 1'b0;
            hit_p1_q     <= 1'b0;
            hit_com_q    <= 1'b0;
            frame_cnt_q  <= 16'd0;
            overrun_q    <= 8'd0;
            timeout_q    <= 1'b0;
            cap_q        <= INIT;
            coord_q      <= INIT;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            busy_cnt_q   <= busy_cnt_d;
            phys_start_q <= phys_start_d;
            commit_q     <= commit_d;
            hit_p1_q     <= hit_p1_d;
            hit_com_q    <= hit_com_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            cap_q        <= cap_d;
            coord_q      <= coord_d;
        end
    end

    assign phys_start  = phys_start_q;
    assign hit_p1      = hit_p1_q;
    assign hit_com     = hit_com_q;
    assign commit      = commit_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_q;
    assign timeout     = timeout_q;
    assign p1_x        = coord_q[0];
    assign p1_y        = coord_q[1];
    assign p2_x        = coord_q[2];
    assign p2_y        = coord_q[3];
    assign ball_x      = coord_q[4];
    assign ball_y      = coord_q[5];

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: two instances (every-frame with short timeout, every-third-frame with long timeout),
// exercised one at a time while the other is held in reset, against a transaction-level model of the frame rules.
module tb_frame_update_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n, use_b;
    logic       enable, vga_vs, player_cover, COM_cover, phys_done;
    logic [9:0] nv [6];

    logic       a_start, a_hp1, a_hcom, a_commit, a_to;
    logic [9:0] a_c [6];
    logic [15:0] a_frame;
    logic [7:0] a_over;
    logic       b_start, b_hp1, b_hcom, b_commit, b_to;
    logic [9:0] b_c [6];
    logic [15:0] b_frame;
    logic [7:0] b_over;

    logic       s_start, s_hp1, s_hcom, s_commit, s_to;
    logic [9:0] s_c [6];
    logic [15:0] s_frame;
    logic [7:0] s_over;

    frame_update_scheduler #(.FRAME_DIV(1), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .enable(enable), .vga_vs(vga_vs),
        .player_cover(player_cover), .COM_cover(COM_cover), .phys_done(phys_done),
        .phys_p1_x(nv[0]), .phys_p1_y(nv[1]), .phys_p2_x(nv[2]), .phys_p2_y(nv[3]),
        .phys_ball_x(nv[4]), .phys_ball_y(nv[5]),
        .phys_start(a_start), .hit_p1(a_hp1), .hit_com(a_hcom),
        .p1_x(a_c[0]), .p1_y(a_c[1]), .p2_x(a_c[2]), .p2_y(a_c[3]), .ball_x(a_c[4]), .ball_y(a_c[5]),
        .commit(a_commit), .frame_cnt(a_frame), .overrun_cnt(a_over), .timeout(a_to)
    );

    frame_update_scheduler #(.FRAME_DIV(3), .TIMEOUT_CYC(2000)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .enable(enable), .vga_vs(vga_vs),
        .player_cover(player_cover), .COM_cover(COM_cover), .phys_done(phys_done),
        .phys_p1_x(nv[0]), .phys_p1_y(nv[1]), .phys_p2_x(nv[2]), .phys_p2_y(nv[3]),
        .phys_ball_x(nv[4]), .phys_ball_y(nv[5]),
        .phys_start(b_start), .hit_p1(b_hp1), .hit_com(b_hcom),
        .p1_x(b_c[0]), .p1_y(b_c[1]), .p2_x(b_c[2]), .p2_y(b_c[3]), .ball_x(b_c[4]), .ball_y(b_c[5]),
        .commit(b_commit), .frame_cnt(b_frame), .overrun_cnt(b_over), .timeout(b_to)
    );

    // Observe whichever instance is under test.
    always_comb begin
        s_start  = use_b ? b_start  : a_start;
        s_hp1    = use_b ? b_hp1    : a_hp1;
        s_hcom   = use_b ? b_hcom   : a_hcom;
        s_commit = use_b ? b_commit : a_commit;
        s_to     = use_b ? b_to     : a_to;
        s_frame  = use_b ? b_frame  : a_frame;
        s_over   = use_b ? b_over   : a_over;
        for (int i = 0; i < 6; i++) s_c[i] = use_b ? b_c[i] : a_c[i];
    end

    // Pulse counters for the selected instance (cumulative over the whole run).
    int start_cnt = 0;
    int commit_cnt = 0;
    always @(negedge clk) begin
        if (s_start === 1'b1) start_cnt++;
        if (s_commit === 1'b1) commit_cnt++;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         fdiv, m_div, m_frame, m_over, m_starts, m_commits;
    bit         m_busy, m_arm, m_to, m_hp1, m_hcom;
    logic [9:0] m_c [6];
    localparam int INITV [6] = '{64, 352, 512, 352, 300, 40};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_div = 0; m_frame = 0; m_over = 0; m_busy = 0; m_to = 0; m_hp1 = 0; m_hcom = 0;
        for (int i = 0; i < 6; i++) m_c[i] = 10'(INITV[i]);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_frame"}, 32'(s_frame), 32'(m_frame & 16'hFFFF));
        chk({tag, "_overrun"}, 32'(s_over), 32'(m_over));
        chk({tag, "_timeout"}, 32'(s_to), 32'(m_to));
        chk({tag, "_hit_p1"}, 32'(s_hp1), 32'(m_hp1));
        chk({tag, "_hit_com"}, 32'(s_hcom), 32'(m_hcom));
        for (int i = 0; i < 6; i++) chk({tag, "_coord"}, 32'(s_c[i]), 32'(m_c[i]));
        chk({tag, "_starts"}, 32'(start_cnt), 32'(m_starts));
        chk({tag, "_commits"}, 32'(commit_cnt), 32'(m_commits));
    endtask

    // One vsync low pulse (lo >= 3). The falling edge is acted on 3 clocks after vga_vs drops.
    task automatic vs_pulse(input int lo, input int hi);
        bit exp_start;
        exp_start = 0;
        m_frame++;
        if (m_busy) begin
            if (m_over < 255) m_over++;
        end else begin
            m_hp1  = player_cover;
            m_hcom = COM_cover;
            if (m_arm) begin
                m_div++;
                if (m_div == fdiv) begin
                    m_div = 0;
                    exp_start = 1;
                end
            end
        end
        vga_vs = 1'b0;
        tick(); tick();
        chk("start_before_lat", 32'(s_start), 32'd0);
        tick();
        chk("start_at_lat3", 32'(s_start), 32'(exp_start));
        if (exp_start) begin
            m_busy = 1;
            m_starts++;
        end
        repeat (lo - 3) tick();
        vga_vs = 1'b1;
        repeat (hi) tick();
        chk("pulse_frame", 32'(s_frame), 32'(m_frame & 16'hFFFF));
        chk("pulse_overrun", 32'(s_over), 32'(m_over));
        chk("pulse_hit_p1", 32'(s_hp1), 32'(m_hp1));
        chk("pulse_hit_com", 32'(s_hcom), 32'(m_hcom));
        chk("pulse_starts", 32'(start_cnt), 32'(m_starts));
    endtask

    // Deliver a done with the values in nv after wait_cyc clocks, then check the commit timing.
    task automatic do_done(input int wait_cyc);
        repeat (wait_cyc) tick();
        phys_done = 1'b1;
        tick();
        phys_done = 1'b0;
        chk("commit_not_yet", 32'(s_commit), 32'd0);
        chk("coord_not_yet", 32'(s_c[0]), 32'(m_c[0]));
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) m_c[i] = (nv[i] > 10'd639) ? 10'd639 : nv[i];
            else            m_c[i] = (nv[i] > 10'd479) ? 10'd479 : nv[i];
        end
        m_commits++;
        m_busy = 0;
        m_arm  = enable;
        chk("commit_pulse", 32'(s_commit), 32'd1);
        for (int i = 0; i < 6; i++) chk("commit_coord", 32'(s_c[i]), 32'(m_c[i]));
        tick();
        chk("commit_one_cycle", 32'(s_commit), 32'd0);
        chk("commit_count", 32'(commit_cnt), 32'(m_commits));
    endtask

    task automatic rand_coords();
        for (int i = 0; i < 6; i++) nv[i] = 10'($urandom_range(0, 1023));
    endtask

    initial begin
        rst_a_n = 0; rst_b_n = 0; use_b = 0; enable = 1; vga_vs = 1;
        player_cover = 0; COM_cover = 0; phys_done = 0;
        for (int i = 0; i < 6; i++) nv[i] = '0;
        m_starts = 0; m_commits = 0; fdiv = 1; m_arm = 0;
        model_reset();

        // ---- Instance A: every frame, 100-cycle timeout ----
        repeat (3) tick();
        chk("rst_start", 32'(s_start), 32'd0);
        chk("rst_commit", 32'(s_commit), 32'd0);
        check_state("rst_a");
        rst_a_n = 1;
        tick(); tick();
        m_arm = 1;

        // First frame: P1 overlap flagged, done 10 clocks after start with p1_x=200.
        player_cover = 1; COM_cover = 0;
        vs_pulse(3, 1);
        chk("first_frame_cnt", 32'(s_frame), 32'd1);
        for (int i = 0; i < 6; i++) chk("first_coord_init", 32'(s_c[i]), 32'(INITV[i]));
        player_cover = 0;
        rand_coords();
        nv[0] = 10'd200;
        do_done(8);
        chk("p1_x_200", 32'(s_c[0]), 32'd200);
        chk("hit_p1_held", 32'(s_hp1), 32'd1);

        // Clamp boundaries, then random frames.
        for (int it = 0; it < 8; it++) begin
            player_cover = 1'($urandom_range(0, 1));
            COM_cover    = 1'($urandom_range(0, 1));
            vs_pulse(3 + int'($urandom_range(0, 2)), 2);
            player_cover = ~player_cover;
            COM_cover    = ~COM_cover;
            rand_coords();
            if (it == 0) begin nv[4] = 10'd700; nv[5] = 10'd500; end
            if (it == 1) begin nv[0] = 10'd640; nv[1] = 10'd480; nv[2] = 10'd639; nv[3] = 10'd479; end
            do_done(int'($urandom_range(1, 20)));
            repeat (int'($urandom_range(1, 4))) tick();
        end
        check_state("random_frames");

        // Done on the last allowed cycle beats the timeout.
        vs_pulse(3, 1);
        rand_coords();
        do_done(98);
        chk("done_wins_timeout", 32'(s_to), 32'd0);

        // No done: abort exactly 100 cycles after the start pulse.
        vs_pulse(3, 1);
        repeat (98) tick();
        chk("timeout_cycle99", 32'(s_to), 32'd0);
        tick();
        m_to = 1; m_busy = 0;
        chk("timeout_cycle100", 32'(s_to), 32'd1);
        repeat (3) tick();
        check_state("after_timeout");
        vs_pulse(3, 1);
        rand_coords();
        do_done(5);
        chk("timeout_sticky", 32'(s_to), 32'd1);

        // Two edges while busy: overruns counted, flags held, one start.
        player_cover = 1; COM_cover = 1;
        vs_pulse(3, 3);
        player_cover = 0; COM_cover = 0;
        vs_pulse(3, 3);
        vs_pulse(3, 3);
        chk("overrun_two", 32'(s_over), 32'd2);
        rand_coords();
        do_done(2);

        // enable dropped mid-transaction still commits, then idles.
        vs_pulse(4, 2);
        enable = 0;
        rand_coords();
        do_done(3);
        repeat (2) tick();
        player_cover = 1; COM_cover = 0;
        vs_pulse(4, 2);
        enable = 1;
        tick(); tick();
        m_arm = 1;
        check_state("enable_drop");

        // ---- Instance B: every third frame, 2000-cycle timeout ----
        rst_a_n = 0; rst_b_n = 0; use_b = 1; fdiv = 3; m_arm = 0;
        model_reset();
        repeat (3) tick();
        check_state("rst_b");
        rst_b_n = 1;
        tick(); tick();
        m_arm = 1;
        for (int e = 1; e <= 6; e++) begin
            player_cover = 1'($urandom_range(0, 1));
            COM_cover    = 1'($urandom_range(0, 1));
            vs_pulse(4, 2);
            chk("div3_start", 32'(m_busy), 32'((e % 3) == 0));
            if (m_busy) begin
                rand_coords();
                do_done(int'($urandom_range(1, 5)));
            end
        end
        check_state("div3");

        // Overrun saturation during one long busy period.
        for (int e = 0; e < 261; e++) begin
            player_cover = 1'($urandom_range(0, 1));
            COM_cover    = 1'($urandom_range(0, 1));
            vs_pulse(3, 3);
            if (e == 257) chk("overrun_at_255", 32'(s_over), 32'd255);
        end
        chk("overrun_sat", 32'(s_over), 32'd255);
        chk("still_busy_no_commit", 32'(commit_cnt), 32'(m_commits));

        // Reset while busy: done arriving around reset must not commit.
        rand_coords();
        phys_done = 1;
        rst_b_n = 0;
        tick(); tick();
        rst_b_n = 1;
        tick();
        phys_done = 0;
        repeat (4) tick();
        model_reset();
        check_state("reset_busy");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
